// File: rtl/vram_cpu_arbiter.sv
// CPU side of the VDP VRAM port: control-port address setup, auto-increment address,
// read-ahead buffer and a single queued access arbitrated against display fetch.
module vram_cpu_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wm0_tick,
  input  logic        rm0_tick,
  input  logic        wm1_tick,
  input  logic        rm1_tick,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_stall,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        cpu_pending,
  output logic        overrun
);

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } op_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic        phase_q, phase_d;
  logic [7:0]  low_q, low_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic        pend_q, pend_d;
  op_t         op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic        cap_q, cap_d;
  logic        ovr_q, ovr_d;
  logic        grant;
  logic [13:0] setup_addr;

  // Reset gating keeps a queued access from reaching VRAM during the reset cycle.
  assign grant      = pend_q && !reset && (!disp_req || (wait_q == WAIT_LIM));
  assign setup_addr = {din[5:0], low_q};

  assign vram_addr   = grant ? op_q.addr : disp_addr;
  assign vram_we     = grant && op_q.we;
  assign vram_wdata  = op_q.data;
  assign disp_stall  = grant && disp_req;
  assign cpu_pending = pend_q;
  assign overrun     = ovr_q;
  assign dout        = rd_buf_q;

  always_comb begin
    phase_d  = phase_q;
    low_d    = low_q;
    addr_d   = addr_q;
    rd_buf_d = rd_buf_q;
    pend_d   = pend_q;
    op_d     = op_q;
    wait_d   = wait_q;
    ovr_d    = ovr_q;
    cap_d    = grant && !op_q.we;

    if (cap_q) rd_buf_d = vram_rdata;

    if (grant)       pend_d = 1'b0;
    else if (pend_q) wait_d = wait_q + 8'd1;

    // Ticks are only accepted while nothing is pending, so queueing never
    // coincides with a grant; a write accepted here overrides a read capture.
    if (rm0_tick) begin
      phase_d = 1'b0;
    end else if (wm0_tick) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        low_d = din;
      end else if (!din[7]) begin
        if (din[6]) begin
          addr_d = setup_addr;
        end else if (pend_q) begin
          addr_d = setup_addr;
          ovr_d  = 1'b1;
        end else begin
          addr_d     = setup_addr + 14'd1;
          op_d.we    = 1'b0;
          op_d.addr  = setup_addr;
          pend_d     = 1'b1;
          wait_d     = 8'd0;
        end
      end
    end else if (wm1_tick) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else begin
        op_d     = '{we: 1'b1, addr: addr_q, data: din};
        rd_buf_d = din;
        addr_d   = addr_q + 14'd1;
        pend_d   = 1'b1;
        wait_d   = 8'd0;
      end
    end else if (rm1_tick) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else begin
        op_d.we   = 1'b0;
        op_d.addr = addr_q;
        addr_d    = addr_q + 14'd1;
        pend_d    = 1'b1;
        wait_d    = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= 1'b0;
      low_q    <= '0;
      addr_q   <= '0;
      rd_buf_q <= '0;
      pend_q   <= 1'b0;
      op_q     <= '0;
      wait_q   <= '0;
      cap_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      low_q    <= low_d;
      addr_q   <= addr_d;
      rd_buf_q <= rd_buf_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      cap_q    <= cap_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_vram_cpu_arbiter.sv
// Bench for vram_cpu_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a transaction-level reference model.
module tb_vram_cpu_arbiter;
  localparam int MAX_WAIT = 8;
  localparam logic [13:0] DA = 14'h0ABC;

  logic        clk = 1'b0;
  logic        reset, wm0_tick, rm0_tick, wm1_tick, rm1_tick, disp_req;
  logic [7:0]  din, dout, vram_wdata, vram_rdata;
  logic [13:0] disp_addr, vram_addr;
  logic        disp_stall, vram_we, cpu_pending, overrun;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vram_cpu_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wm0_tick(wm0_tick), .rm0_tick(rm0_tick), .wm1_tick(wm1_tick), .rm1_tick(rm1_tick),
    .din(din), .dout(dout),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_stall(disp_stall),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cpu_pending(cpu_pending), .overrun(overrun)
  );

  // VRAM: synchronous write, data valid one cycle after address
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    {wm0_tick, rm0_tick, wm1_tick, rm1_tick} = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {wm0_tick, rm0_tick, wm1_tick, rm1_tick} = 4'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          k;      // 0 none, 1 wm0, 2 rm0, 3 wm1, 4 rm1
    logic [7:0]  din;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic        pend;
    logic [7:0]  dout;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(int k, logic [7:0] d, logic we, logic [13:0] a,
                              logic [7:0] wd, logic p, logic [7:0] o);
    vec_t v;
    v.k = k; v.din = d; v.we = we; v.addr = a; v.wdata = wd; v.pend = p; v.dout = o;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } op_t;
  op_t        pq[$];
  logic [7:0] em [16384];
  bit         m_phase, m_ovr, m_capv;
  logic [7:0] m_low, m_rdbuf, m_capval, m_ldata;
  int         m_addr, m_age;

  task automatic model_reset();
    pq.delete();
    m_phase = 0; m_ovr = 0; m_capv = 0;
    m_low = 0; m_rdbuf = 0; m_capval = 0; m_ldata = 0;
    m_addr = 0; m_age = 0;
  endtask

  function automatic bit model_grant();
    return (pq.size() != 0) && !reset && (!disp_req || m_age == MAX_WAIT);
  endfunction

  task automatic model_check();
    bit g;
    g = model_grant();
    chk("r_we", 32'(vram_we), 32'(g && pq[0].we));
    chk("r_addr", 32'(vram_addr), 32'(g ? pq[0].addr : disp_addr));
    chk("r_wdata", 32'(vram_wdata), 32'(m_ldata));
    chk("r_stall", 32'(disp_stall), 32'(g && disp_req));
    chk("r_pend", 32'(cpu_pending), 32'(pq.size() != 0));
    chk("r_dout", 32'(dout), 32'(m_rdbuf));
    chk("r_ovr", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_edge();
    bit pend, g;
    logic [13:0] a;
    pend = (pq.size() != 0);
    g = model_grant();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_capv) m_rdbuf = m_capval;
    m_capv = 0;
    if (g) begin
      if (pq[0].we) em[pq[0].addr] = pq[0].data;
      else begin
        m_capv = 1;
        m_capval = em[pq[0].addr];
      end
      void'(pq.pop_front());
    end else if (pend) m_age++;
    if (rm0_tick) m_phase = 0;
    else if (wm0_tick) begin
      if (!m_phase) m_low = din;
      else if (!din[7]) begin
        a = {din[5:0], m_low};
        if (din[6]) m_addr = int'(a);
        else if (pend) begin
          m_addr = int'(a);
          m_ovr = 1;
        end else begin
          pq.push_back('{1'b0, a, m_ldata});
          m_age = 0;
          m_addr = (int'(a) + 1) % 16384;
        end
      end
      m_phase = !m_phase;
    end else if (wm1_tick || rm1_tick) begin
      if (pend) m_ovr = 1;
      else begin
        pq.push_back('{wm1_tick, 14'(m_addr), wm1_tick ? din : m_ldata});
        if (wm1_tick) begin
          m_ldata = din;
          m_rdbuf = din;
        end
        m_addr = (m_addr + 1) % 16384;
        m_age = 0;
      end
    end
  endtask

  initial begin
    int nw;
    reset = 1'b0; din = '0; disp_req = 1'b0; disp_addr = DA;
    {wm0_tick, rm0_tick, wm1_tick, rm1_tick} = 4'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h1235] = 8'h77;
    mem[14'h3FFF] = 8'h5C;
    mem[14'h0000] = 8'h11;
    do_reset();

    // setup write at 0x1234, readback prefetch, then read setup wrapping 0x3FFF -> 0
    vt.push_back(mk(0, 8'h00, 0, DA,       8'h00, 0, 8'h00));
    vt.push_back(mk(1, 8'h34, 0, DA,       8'h00, 0, 8'h00));
    vt.push_back(mk(1, 8'h52, 0, DA,       8'h00, 0, 8'h00));
    vt.push_back(mk(3, 8'hAA, 0, DA,       8'h00, 0, 8'h00));
    vt.push_back(mk(0, 8'h00, 1, 14'h1234, 8'hAA, 1, 8'hAA));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'hAA));
    vt.push_back(mk(4, 8'h00, 0, DA,       8'hAA, 0, 8'hAA));
    vt.push_back(mk(0, 8'h00, 0, 14'h1235, 8'hAA, 1, 8'hAA));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'hAA));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'h77));
    vt.push_back(mk(1, 8'hFF, 0, DA,       8'hAA, 0, 8'h77));
    vt.push_back(mk(1, 8'h3F, 0, DA,       8'hAA, 0, 8'h77));
    vt.push_back(mk(0, 8'h00, 0, 14'h3FFF, 8'hAA, 1, 8'h77));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'h77));
    vt.push_back(mk(4, 8'h00, 0, DA,       8'hAA, 0, 8'h5C));
    vt.push_back(mk(0, 8'h00, 0, 14'h0000, 8'hAA, 1, 8'h5C));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'h5C));
    vt.push_back(mk(0, 8'h00, 0, DA,       8'hAA, 0, 8'h11));

    foreach (vt[i]) begin
      wm0_tick = (vt[i].k == 1); rm0_tick = (vt[i].k == 2);
      wm1_tick = (vt[i].k == 3); rm1_tick = (vt[i].k == 4);
      din = vt[i].din;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), 32'(vram_we), 32'(vt[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(vram_addr), 32'(vt[i].addr));
      chk($sformatf("vec%0d_wdata", i), 32'(vram_wdata), 32'(vt[i].wdata));
      chk($sformatf("vec%0d_pend", i), 32'(cpu_pending), 32'(vt[i].pend));
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].dout));
      chk($sformatf("vec%0d_stall", i), 32'(disp_stall), 32'd0);
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'd0);
      clk1();
    end
    chk("mem_1234", 32'(mem[14'h1234]), 32'h0000_00AA);

    // display priority: CPU waits MAX_WAIT cycles then takes one stalled cycle
    do_reset();
    disp_req = 1'b1; disp_addr = 14'h0100;
    wm1_tick = 1'b1; din = 8'h5A;
    @(negedge clk);
    chk("dp_q_pend", 32'(cpu_pending), 32'd0);
    clk1();
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      chk("dp_wait_addr", 32'(vram_addr), 32'h0100);
      chk("dp_wait_stall", 32'(disp_stall), 32'd0);
      chk("dp_wait_pend", 32'(cpu_pending), 32'd1);
      clk1();
    end
    @(negedge clk);
    chk("dp_g_stall", 32'(disp_stall), 32'd1);
    chk("dp_g_we", 32'(vram_we), 32'd1);
    chk("dp_g_addr", 32'(vram_addr), 32'h0000);
    chk("dp_g_wdata", 32'(vram_wdata), 32'h5A);
    clk1();
    @(negedge clk);
    chk("dp_after_stall", 32'(disp_stall), 32'd0);
    chk("dp_after_pend", 32'(cpu_pending), 32'd0);
    chk("dp_after_addr", 32'(vram_addr), 32'h0100);

    // overrun: second write while pending is dropped
    clk1();
    wm1_tick = 1'b1; din = 8'h01;
    clk1();
    wm1_tick = 1'b1; din = 8'h02;
    @(negedge clk);
    chk("ov_pend", 32'(cpu_pending), 32'd1);
    clk1();
    @(negedge clk);
    chk("ov_flag", 32'(overrun), 32'd1);
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vram_we) begin
        nw++;
        chk("ov_waddr", 32'(vram_addr), 32'h0001);
        chk("ov_wdata", 32'(vram_wdata), 32'h01);
      end
      clk1();
    end
    chk("ov_nwrites", 32'(nw), 32'd1);
    chk("ov_mem1", 32'(mem[1]), 32'h01);
    disp_req = 1'b0; rm1_tick = 1'b1;
    @(negedge clk);
    chk("ov_dout", 32'(dout), 32'h01);
    clk1();
    @(negedge clk);
    chk("ov_next_addr", 32'(vram_addr), 32'h0002);
    chk("ov_next_we", 32'(vram_we), 32'd0);
    clk1();
    clk1();

    // status read resets control phase
    wm0_tick = 1'b1; din = 8'h10; clk1();
    rm0_tick = 1'b1; clk1();
    wm0_tick = 1'b1; din = 8'h20; clk1();
    wm0_tick = 1'b1; din = 8'h40; clk1();
    @(negedge clk);
    chk("ph_no_read", 32'(cpu_pending), 32'd0);
    chk("ph_ovr_sticky", 32'(overrun), 32'd1);
    clk1();
    wm1_tick = 1'b1; din = 8'h99; clk1();
    @(negedge clk);
    chk("ph_we", 32'(vram_we), 32'd1);
    chk("ph_addr", 32'(vram_addr), 32'h0020);
    chk("ph_wdata", 32'(vram_wdata), 32'h99);
    clk1();

    // reset with a write queued behind display
    disp_req = 1'b1;
    wm1_tick = 1'b1; din = 8'h33; clk1();
    reset = 1'b1;
    @(negedge clk);
    chk("rs_we_in_reset", 32'(vram_we), 32'd0);
    clk1();
    reset = 1'b0;
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vram_we) nw++;
      if (i == 0) begin
        chk("rs_pend", 32'(cpu_pending), 32'd0);
        chk("rs_dout", 32'(dout), 32'd0);
        chk("rs_ovr", 32'(overrun), 32'd0);
      end
      clk1();
    end
    chk("rs_no_we", 32'(nw), 32'd0);

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 16384; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v;
      em[i] = v;
    end
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = $urandom_range(0, 9);
      reset = ($urandom_range(0, 299) == 0);
      wm0_tick = (k == 1) || (k == 7);
      rm0_tick = (k == 2);
      wm1_tick = (k == 3) || (k == 4);
      rm1_tick = (k == 5) || (k == 6);
      din = 8'($urandom);
      disp_req = ($urandom_range(0, 3) != 0);
      disp_addr = 14'($urandom);
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_cpu_arbiter.md
Name: vram_cpu_arbiter

Overview:
- Sequences CPU accesses to VRAM through the VDP data port (mode1) and shares the single VRAM port with the display fetch engine.
- Decodes the VRAM address-setup form of the 2-byte control write, so the control-port phase tracks the config-register path exactly.
- Holds the 14-bit auto-incrementing VRAM address and the read-ahead buffer.
- Display fetch has priority, with a bounded-wait override for the CPU.

Parameters:
- MAX_WAIT, 8: cycles a pending CPU access may wait before it preempts display for one cycle (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- wm0_tick  input  1  control-port write strobe.
- rm0_tick  input  1  status read strobe; clears control phase.
- wm1_tick  input  1  data-port write strobe.
- rm1_tick  input  1  data-port read strobe.
- din  input  8  CPU data, stable during any tick.
- dout  output  8  read-ahead buffer; stable during rm1_tick.
- disp_req  input  1  display wants the VRAM port this cycle.
- disp_addr  input  14  display fetch address.
- disp_stall  output  1  display denied this cycle (CPU override).
- vram_addr  output  14  VRAM address, combinational mux.
- vram_we  output  1  VRAM write enable.
- vram_wdata  output  8  VRAM write data.
- vram_rdata  input  8  VRAM read data, valid 1 cycle after address.
- cpu_pending  output  1  CPU access queued, not yet granted.
- overrun  output  1  sticky: CPU data access dropped.

Behaviour:
- Reset: clock edge with reset=1 clears:
  - phase, first-byte latch, addr_reg (14'h0000), rd_buf (dout=0)
  - pending, op_*, wait counter
  - capture flag, overrun
- Reset also drops any queued or in-flight access; no vram_we is issued after reset.
- Control phase:
  - wm0_tick toggles phase.
  - rm0_tick forces phase=0 and has priority over wm0_tick.
  - phase=0 write: latch din as low byte.
  - phase=1 write with din[7]=0: addr_reg = {din[5:0], low}.
    - If din[6]=0, also queue a read at that address and set addr_reg = that address + 1.
  - phase=1 write with din[7]=1 (register write): no action here beyond the phase toggle.
- Data write (wm1_tick, not pending):
  - Queue op write: op_addr=addr_reg, op_data=din.
  - rd_buf<=din.
  - addr_reg<=addr_reg+1.
- Data read (rm1_tick, not pending):
  - dout shows the current rd_buf.
  - Queue op read: op_addr=addr_reg.
  - addr_reg<=addr_reg+1.
- Address increment wraps 14'h3FFF -> 14'h0000.
- Queueing sets pending=1 and clears the wait counter. Op fields are latched at queue time; a later address setup does not alter a queued op.
- Overrun:
  - wm1_tick or rm1_tick while pending=1 is dropped: no addr_reg, rd_buf or op change.
  - overrun<=1, sticky until reset.
  - A read-setup control write while pending=1 still loads addr_reg to the new address (no +1), drops its read, and sets overrun.
- Arbitration per cycle, with pending=1:
  - Grant the CPU if disp_req=0, or if wait count == MAX_WAIT.
  - Otherwise increment the wait count.
  - Grant cycle: vram_addr=op_addr, vram_we=op_we, vram_wdata=op_data, pending<=0.
  - disp_stall=1 only when granting while disp_req=1.
- Non-grant cycles: vram_addr=disp_addr, vram_we=0, vram_wdata=op_data, disp_stall=0.
- Read completion: the cycle after a read grant, rd_buf<=vram_rdata, regardless of disp_req.
  - If a wm1_tick is accepted in that same cycle, the din write to rd_buf wins.
- A new request may be queued in the cycle after any grant.
- Queue and grant never occur in the same cycle, so minimum CPU latency is tick -> grant next cycle.
- cpu_pending = pending.

Test Plan:
- Setup write: wm0 0x34, wm0 0x52 (addr 0x1234, write mode); wm1 0xAA, disp_req=0 -> next cycle vram_we=1, vram_addr=0x1234, wdata=0xAA; addr_reg=0x1235.
- Read setup: wm0 0xFF, wm0 0x3F with VRAM[0x3FFF]=0x5C, VRAM[0]=0x11:
  - Read grant at 0x3FFF; dout=0x5C after capture.
  - rm1 returns 0x5C and fetches 0x0000 (wrap); next rm1 returns 0x11.
- Display priority: disp_req held 1, wm1 queued, MAX_WAIT=8:
  - vram_addr follows disp_addr for 8 cycles, then 1 grant cycle with disp_stall=1.
  - disp_stall returns 0 afterwards.
- Overrun: disp_req=1; wm1 0x01 then wm1 0x02 while pending -> overrun=1; only 0x01 written; addr_reg advanced by 1.
- Phase reset: wm0 0x10, rm0, wm0 0x20, wm0 0x40 -> addr_reg=0x0020 (write mode); no read queued.
- Reset mid-op: disp_req=1, wm1 queued, reset for 1 cycle -> no vram_we ever; cpu_pending=0, dout=0, overrun=0.
